mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM->WB pipeline register, directly downstream of the MEM stage (data cache + main memory).
//  Lane-selects and sign/zero-extends load data from the cache word (readDataM).
//  Selects the writeback result and inserts bubbles while the cache stalls.
//  Keeps saturating performance counters for stall cycles, retired loads and retired stores.
// PARAMETERS
//  CNT_W  32  width of each performance counter (valid range 8..32)
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  rst              in   1      synchronous, active-high reset
//  cacheStallM      in   1      MEM stage stall (cache miss in progress)
//  flushW           in   1      kill the instruction entering WB this cycle
//  validM           in   1      MEM slot holds a real instruction
//  regWriteM        in   1      instruction writes rd
//  rdM              in   5      destination register
//  resultSrcM       in   2      00=ALU, 01=load data, 10=PC+4, 11=ALU
//  aluResultM       in   32     ALU result / load-store address
//  readDataM        in   32     aligned word from the data cache
//  pcPlus4M         in   32     PC+4 of the MEM instruction
//  addressingModeM  in   3      RISC-V funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  memReadM         in   1      load instruction
//  memWriteM        in   1      store instruction
//  cntClear         in   1      zero all performance counters
//  validW           out  1      WB slot holds a real instruction
//  regWriteW        out  1      register-file write enable
//  rdW              out  5      register-file write address
//  resultW          out  32     register-file write data
//  stallCycles      out  CNT_W  count of cycles with validM & cacheStallM
//  loadCount        out  CNT_W  count of retired loads
//  storeCount       out  CNT_W  count of retired stores
// BEHAVIOUR
//  - Reset: rst is synchronous and active-high. While rst=1, every output register is driven to 0 at the next edge.
//  - Latency: fixed 1 cycle, MEM inputs -> W outputs. No combinational path from input to output.
//  - Definition: adv = validM & ~cacheStallM & ~flushW.
//  - Each edge with adv=1:
//      validW<=1; rdW<=rdM; regWriteW<=regWriteM & (rdM!=0); resultW<=selected result.
//  - Each edge with adv=0 (stall, flush, or invalid input): insert a bubble.
//      validW<=0; regWriteW<=0; rdW<=0; resultW holds its previous value.
//      The stalled MEM instruction therefore retires exactly once, on the first edge after cacheStallM falls.
//  - Priority: rst > flushW > cacheStallM > normal advance.
//  - Load extension: off = aluResultM[1:0]; byte = readDataM[8*off +: 8]; half = readDataM[16*off[1] +: 16].
//      LB/LBU: sign-/zero-extend byte.
//      LH/LHU: sign-/zero-extend half; off[0] is ignored, with no fault.
//      LW and the undefined codes 011/110/111: full word; off is ignored.
//  - Result mux: resultSrcM=01 selects the extended load data; 10 selects pcPlus4M; 00 and 11 select aluResultM.
//  - Counters: each is CNT_W wide and saturates at all-ones, never wrapping. Per-edge priority: rst > cntClear > increment.
//      stallCycles +1 when validM & cacheStallM (flushW does not matter).
//      loadCount   +1 when adv & memReadM.
//      storeCount  +1 when adv & memWriteM.
//      memReadM & memWriteM both set on one instruction: both counters increment.
//  - Reset mid-stall: all state is cleared and the pending instruction is dropped. After rst falls, the next adv retires normally.
// TESTING
//  1. LB at addr 0x1003, readDataM=0x80FF_1234, rd=5, resultSrc=01
//       -> next cycle: validW=1, rdW=5, resultW=0xFFFF_FF80, loadCount=1.
//  2. LHU at addr 0x2002, readDataM=0xBEEF_0001 -> resultW=0x0000_BEEF.
//     LH at the same address -> resultW=0xFFFF_BEEF.
//  3. Load with cacheStallM=1 for 4 cycles, then 0
//       -> validW=0 and regWriteW=0 for 4 cycles; one retire on the 5th edge;
//          stallCycles=4, loadCount=1.
//  4. ALU op with rd=0, regWriteM=1, aluResult=0x1234
//       -> regWriteW=0, validW=1, resultW=0x1234.
//     JAL with resultSrc=10, pcPlus4=0x104 -> resultW=0x104.
//  5. Same cycle flushW=1 and cacheStallM=1 with a valid store
//       -> bubble; storeCount unchanged; stallCycles +1.
//     cntClear=1 on that cycle -> all counters read 0 next cycle.
//  6. CNT_W=8: hold a stall for 300 cycles -> stallCycles=0xFF, no wrap.
//     Assert rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: load lane-select/extension, writeback result mux,
// bubble insertion on stall/flush, and saturating performance counters.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cacheStallM,
  input  logic             flushW,
  input  logic             validM,
  input  logic             regWriteM,
  input  logic [4:0]       rdM,
  input  logic [1:0]       resultSrcM,
  input  logic [31:0]      aluResultM,
  input  logic [31:0]      readDataM,
  input  logic [31:0]      pcPlus4M,
  input  logic [2:0]       addressingModeM,
  input  logic             memReadM,
  input  logic             memWriteM,
  input  logic             cntClear,
  output logic             validW,
  output logic             regWriteW,
  output logic [4:0]       rdW,
  output logic [31:0]      resultW,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] loadCount,
  output logic [CNT_W-1:0] storeCount
);

  function automatic logic [31:0] load_ext(input logic [2:0]  mode,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    case (off)
      2'd0:    byte_s = signed'(word[7:0]);
      2'd1:    byte_s = signed'(word[15:8]);
      2'd2:    byte_s = signed'(word[23:16]);
      default: byte_s = signed'(word[31:24]);
    endcase
    // Halfword lane comes from off[1] alone; a misaligned off[0] is tolerated.
    half_s = off[1] ? signed'(word[31:16]) : signed'(word[15:0]);
    case (mode)
      3'b000:  load_ext = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_ext = {{16{half_s[15]}}, half_s};
      3'b100:  load_ext = {24'd0, byte_s};
      3'b101:  load_ext = {16'd0, half_s};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic        adv_p0;
  logic [31:0] load_p0;
  logic [31:0] res_p0;

  assign adv_p0  = validM & ~cacheStallM & ~flushW;
  assign load_p0 = load_ext(addressingModeM, aluResultM[1:0], readDataM);

  always_comb begin
    res_p0 = aluResultM;
    case (resultSrcM)
      2'b01:   res_p0 = load_p0;
      2'b10:   res_p0 = pcPlus4M;
      default: res_p0 = aluResultM;
    endcase
  end

  // ---- MEM -> WB register boundary ----
  logic             vld_p1;
  logic             rw_p1;
  logic [4:0]       rd_p1;
  logic [31:0]      res_p1;
  logic [CNT_W-1:0] stall_cnt_p1;
  logic [CNT_W-1:0] load_cnt_p1;
  logic [CNT_W-1:0] store_cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      rw_p1  <= 1'b0;
      rd_p1  <= 5'd0;
      res_p1 <= 32'd0;
    end else if (adv_p0) begin
      vld_p1 <= 1'b1;
      rw_p1  <= regWriteM & (rdM != 5'd0);
      rd_p1  <= rdM;
      res_p1 <= res_p0;
    end else begin
      // Bubble: result data is left as-is, only control is squashed.
      vld_p1 <= 1'b0;
      rw_p1  <= 1'b0;
      rd_p1  <= 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cntClear) begin
      stall_cnt_p1 <= '0;
      load_cnt_p1  <= '0;
      store_cnt_p1 <= '0;
    end else begin
      if (validM && cacheStallM) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (adv_p0 && memReadM)    load_cnt_p1  <= sat_inc(load_cnt_p1);
      if (adv_p0 && memWriteM)   store_cnt_p1 <= sat_inc(store_cnt_p1);
    end
  end

  assign validW      = vld_p1;
  assign regWriteW   = rw_p1;
  assign rdW         = rd_p1;
  assign resultW     = res_p1;
  assign stallCycles = stall_cnt_p1;
  assign loadCount   = load_cnt_p1;
  assign storeCount  = store_cnt_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus stall, saturation and reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, cacheStallM, flushW, validM, regWriteM;
  logic [4:0]  rdM;
  logic [1:0]  resultSrcM;
  logic [31:0] aluResultM, readDataM, pcPlus4M;
  logic [2:0]  addressingModeM;
  logic        memReadM, memWriteM, cntClear;

  logic        validW, regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW, stallCycles, loadCount, storeCount;

  logic        validW8, regWriteW8;
  logic [4:0]  rdW8;
  logic [31:0] resultW8;
  logic [7:0]  stallCycles8, loadCount8, storeCount8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cacheStallM(cacheStallM), .flushW(flushW),
    .validM(validM), .regWriteM(regWriteM), .rdM(rdM), .resultSrcM(resultSrcM),
    .aluResultM(aluResultM), .readDataM(readDataM), .pcPlus4M(pcPlus4M),
    .addressingModeM(addressingModeM), .memReadM(memReadM), .memWriteM(memWriteM),
    .cntClear(cntClear), .validW(validW), .regWriteW(regWriteW), .rdW(rdW),
    .resultW(resultW), .stallCycles(stallCycles), .loadCount(loadCount),
    .storeCount(storeCount)
  );

  mem_wb_stage #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .cacheStallM(cacheStallM), .flushW(flushW),
    .validM(validM), .regWriteM(regWriteM), .rdM(rdM), .resultSrcM(resultSrcM),
    .aluResultM(aluResultM), .readDataM(readDataM), .pcPlus4M(pcPlus4M),
    .addressingModeM(addressingModeM), .memReadM(memReadM), .memWriteM(memWriteM),
    .cntClear(cntClear), .validW(validW8), .regWriteW(regWriteW8), .rdW(rdW8),
    .resultW(resultW8), .stallCycles(stallCycles8), .loadCount(loadCount8),
    .storeCount(storeCount8)
  );

  typedef struct {
    logic [31:0] valid, stall, flush, rw, rd, src, alu, rdata, pc4, mode, mr, mw, clr;
    logic [31:0] e_vld, e_rw, e_rd, e_res, e_sc, e_lc, e_st;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    validM          = v.valid[0];
    cacheStallM     = v.stall[0];
    flushW          = v.flush[0];
    regWriteM       = v.rw[0];
    rdM             = v.rd[4:0];
    resultSrcM      = v.src[1:0];
    aluResultM      = v.alu;
    readDataM       = v.rdata;
    pcPlus4M        = v.pc4;
    addressingModeM = v.mode[2:0];
    memReadM        = v.mr[0];
    memWriteM       = v.mw[0];
    cntClear        = v.clr[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input logic vld, input logic rw,
                         input logic [4:0] rd, input logic [31:0] res);
    check({tag, ".validW"},    {31'd0, validW},    {31'd0, vld});
    check({tag, ".regWriteW"}, {31'd0, regWriteW}, {31'd0, rw});
    check({tag, ".rdW"},       {27'd0, rdW},       {27'd0, rd});
    check({tag, ".resultW"},   resultW,            res);
  endtask

  vec_t seq;

  initial begin
    //           valid stall flush rw rd src alu rdata pc4 mode mr mw clr | vld rw rd res sc lc st
    vecs[0]  = '{1,0,0,1,5,1,'h1003,'h80FF1234,0,0,1,0,0,        1,1,5,'hFFFFFF80,0,1,0};
    vecs[1]  = '{1,0,0,1,6,1,'h2002,'hBEEF0001,0,5,1,0,0,        1,1,6,'h0000BEEF,0,2,0};
    vecs[2]  = '{1,0,0,1,7,1,'h2002,'hBEEF0001,0,1,1,0,0,        1,1,7,'hFFFFBEEF,0,3,0};
    vecs[3]  = '{1,0,0,1,8,1,'h1002,'h80FF1234,0,4,1,0,0,        1,1,8,'h000000FF,0,4,0};
    vecs[4]  = '{1,0,0,1,9,1,'h3001,'hDEADBEEF,0,2,1,0,0,        1,1,9,'hDEADBEEF,0,5,0};
    vecs[5]  = '{1,0,0,1,9,1,'h2001,'h12348765,0,1,1,0,0,        1,1,9,'hFFFF8765,0,6,0};
    vecs[6]  = '{1,0,0,1,3,1,'h0003,'h11223344,0,6,1,0,0,        1,1,3,'h11223344,0,7,0};
    vecs[7]  = '{1,0,0,1,0,0,'h1234,'hFFFFFFFF,0,0,0,0,0,        1,0,0,'h00001234,0,7,0};
    vecs[8]  = '{1,0,0,1,1,2,'h0055,0,'h104,0,0,0,0,             1,1,1,'h00000104,0,7,0};
    vecs[9]  = '{1,0,0,1,2,3,'hCAFEF00D,'h1,'h8,0,0,0,0,         1,1,2,'hCAFEF00D,0,7,0};
    vecs[10] = '{1,0,0,0,0,0,'h0040,0,0,2,0,1,0,                 1,0,0,'h00000040,0,7,1};
    vecs[11] = '{0,0,0,1,3,0,'h0099,0,0,0,1,0,0,                 0,0,0,'h00000040,0,7,1};
    vecs[12] = '{1,1,1,0,0,0,'h0044,0,0,2,0,1,0,                 0,0,0,'h00000040,1,7,1};
    vecs[13] = '{1,0,0,1,4,1,'h0010,'h00000077,0,2,1,1,0,        1,1,4,'h00000077,1,8,2};
    vecs[14] = '{1,1,1,0,0,0,'h0044,0,0,2,0,1,1,                 0,0,0,'h00000077,0,0,0};
    vecs[15] = '{1,0,0,1,12,1,'h0020,'hA5A5A5A5,0,2,1,0,1,       1,1,12,'hA5A5A5A5,0,0,0};

    seq = vecs[11];
    drive(seq);
    cntClear = 1'b0;
    rst = 1'b1;
    step();
    step();
    check_w("reset", 1'b0, 1'b0, 5'd0, 32'd0);
    check("reset.stallCycles", stallCycles, 32'd0);
    check("reset.loadCount", loadCount, 32'd0);
    check("reset.storeCount", storeCount, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      check_w($sformatf("vec%0d", i), vecs[i].e_vld[0], vecs[i].e_rw[0],
              vecs[i].e_rd[4:0], vecs[i].e_res);
      check($sformatf("vec%0d.stallCycles", i), stallCycles, vecs[i].e_sc);
      check($sformatf("vec%0d.loadCount", i), loadCount, vecs[i].e_lc);
      check($sformatf("vec%0d.storeCount", i), storeCount, vecs[i].e_st);
    end

    // Load held by a 4-cycle cache stall, then retiring exactly once.
    seq = vecs[11];
    drive(seq);
    validM = 1'b0;
    cntClear = 1'b1;
    step();
    cntClear = 1'b0;
    seq = vecs[4];
    seq.rd = 11;
    seq.rdata = 'h13579BDF;
    seq.stall = 1;
    drive(seq);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall%0d.validW", i), {31'd0, validW}, 32'd0);
      check($sformatf("stall%0d.regWriteW", i), {31'd0, regWriteW}, 32'd0);
      check($sformatf("stall%0d.stallCycles", i), stallCycles, i + 1);
    end
    cacheStallM = 1'b0;
    step();
    check_w("retire", 1'b1, 1'b1, 5'd11, 32'h13579BDF);
    check("retire.stallCycles", stallCycles, 32'd4);
    check("retire.loadCount", loadCount, 32'd1);
    validM = 1'b0;
    step();
    check("after_retire.validW", {31'd0, validW}, 32'd0);
    check("after_retire.loadCount", loadCount, 32'd1);

    // Long stall: 8-bit counter saturates, 32-bit one keeps counting.
    cntClear = 1'b1;
    step();
    cntClear = 1'b0;
    validM = 1'b1;
    cacheStallM = 1'b1;
    for (int i = 0; i < 300; i++) step();
    check("sat.stallCycles8", {24'd0, stallCycles8}, 32'h000000FF);
    check("sat.stallCycles32", stallCycles, 32'd300);
    check("sat.resultW_held", resultW, 32'h13579BDF);

    // Reset in the middle of the stall drops everything.
    rst = 1'b1;
    step();
    check_w("midrst", 1'b0, 1'b0, 5'd0, 32'd0);
    check("midrst.stallCycles", stallCycles, 32'd0);
    check("midrst.loadCount", loadCount, 32'd0);
    check("midrst.stallCycles8", {24'd0, stallCycles8}, 32'd0);
    check("midrst.resultW8", resultW8, 32'd0);
    rst = 1'b0;
    cacheStallM = 1'b0;
    readDataM = 32'h0BADF00D;
    rdM = 5'd10;
    step();
    check_w("postrst", 1'b1, 1'b1, 5'd10, 32'h0BADF00D);
    check("postrst.loadCount", loadCount, 32'd1);
    check("postrst.stallCycles", stallCycles, 32'd0);
    check("postrst.loadCount8", {24'd0, loadCount8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
